// File: rtl/sha_pkg.sv
// Shared SHA-256 definitions: word width, round-constant table and hash-state type.
// Used by the message scheduler and the round datapath.
package sha_pkg;

  localparam int WORD_W     = 32;
  localparam int ROUNDS_MAX = 64;

  typedef logic [WORD_W-1:0] word_t;

  typedef struct packed {
    word_t a;
    word_t b;
    word_t c;
    word_t d;
    word_t e;
    word_t f;
    word_t g;
    word_t h;
  } HashState;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } sched_state_e;

  localparam word_t K_TABLE [ROUNDS_MAX] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

endpackage

// File: rtl/sha_ssig.sv
// Combinational SHA-256 small sigma: SEL=0 gives sigma0, SEL=1 gives sigma1.
module sha_ssig
  import sha_pkg::*;
#(
  parameter int SEL = 0
) (
  input  logic [WORD_W-1:0] i_x,
  output logic [WORD_W-1:0] o_y
);

  generate
    if (SEL == 0) begin : g_sig0
      assign o_y = {i_x[6:0], i_x[31:7]} ^ {i_x[17:0], i_x[31:18]} ^ (i_x >> 3);
    end else begin : g_sig1
      assign o_y = {i_x[16:0], i_x[31:17]} ^ {i_x[18:0], i_x[31:19]} ^ (i_x >> 10);
    end
  endgenerate

endmodule

// File: rtl/sha_msg_sched.sv
// SHA-256 message scheduler: loads one 512-bit block, then streams W[t]/K[t] pairs
// through a 16-word sliding window that derives W[16..] on the fly.
module sha_msg_sched
  import sha_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_out,
  output logic [31:0]  k_out,
  output logic [5:0]   w_idx,
  output logic         w_last
);

  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

  sched_state_e r_state;
  sched_state_e w_state_next;
  word_t        r_win [16];
  word_t        w_win_shift [16];
  word_t        w_blk_word [16];
  logic [5:0]   r_t;
  word_t        w_s0;
  word_t        w_s1;
  word_t        w_new;
  logic         w_load;
  logic         w_hs;
  logic         w_at_last;

  sha_ssig #(.SEL(0)) u_ssig0 (.i_x(r_win[1]),  .o_y(w_s0));
  sha_ssig #(.SEL(1)) u_ssig1 (.i_x(r_win[14]), .o_y(w_s1));

  assign w_new     = w_s1 + r_win[9] + w_s0 + r_win[0];
  assign w_load    = (r_state == S_IDLE) && blk_valid;
  assign w_hs      = (r_state == S_RUN) && w_ready;
  assign w_at_last = (r_t == LAST_IDX);

  // Word 0 of the block is the most significant 32 bits; the tail slot takes the new W.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_win
      assign w_blk_word[gi] = blk_data[511-32*gi -: 32];
      if (gi == 15) begin : g_tail
        assign w_win_shift[gi] = w_new;
      end else begin : g_body
        assign w_win_shift[gi] = r_win[gi+1];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (blk_valid) w_state_next = S_RUN;
      S_RUN:   if (w_ready && w_at_last) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    blk_ready = (r_state == S_IDLE);
    w_valid   = (r_state == S_RUN);
    w_out     = r_win[0];
    k_out     = K_TABLE[r_t];
    w_idx     = r_t;
    w_last    = (r_state == S_RUN) && w_at_last;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_t <= '0;
      for (int i = 0; i < 16; i++) r_win[i] <= '0;
    end else if (w_load) begin
      r_t <= '0;
      r_win <= w_blk_word;
    end else if (w_hs) begin
      // The final handshake only rewinds t; the window content no longer matters.
      if (w_at_last) begin
        r_t <= '0;
      end else begin
        r_t   <= r_t + 6'd1;
        r_win <= w_win_shift;
      end
    end
  end

endmodule

// File: tb/tb_sha_msg_sched.sv
// Directed bench for sha_msg_sched: full-length and 16-round builds, checked against
// an independent schedule model and literal SHA-256 constants.
module tb_sha_msg_sched;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         blk_valid = 1'b0;
  logic         w_ready = 1'b1;
  logic [511:0] blk_data = '0;
  logic         dut_sel = 1'b0;

  logic bv1, bv2, wr1, wr2;
  logic br1, wv1, wl1, br2, wv2, wl2;
  logic [31:0] wo1, ko1, wo2, ko2;
  logic [5:0]  wi1, wi2;
  logic m_br, m_wv, m_wl;
  logic [31:0] m_wo, m_ko;
  logic [5:0]  m_wi;

  assign bv1 = blk_valid & ~dut_sel;
  assign bv2 = blk_valid & dut_sel;
  assign wr1 = w_ready & ~dut_sel;
  assign wr2 = w_ready & dut_sel;
  assign m_br = dut_sel ? br2 : br1;
  assign m_wv = dut_sel ? wv2 : wv1;
  assign m_wo = dut_sel ? wo2 : wo1;
  assign m_ko = dut_sel ? ko2 : ko1;
  assign m_wi = dut_sel ? wi2 : wi1;
  assign m_wl = dut_sel ? wl2 : wl1;

  sha_msg_sched #(.ROUNDS(64)) u_dut64 (
    .clk(clk), .rst(rst), .blk_valid(bv1), .blk_ready(br1), .blk_data(blk_data),
    .w_valid(wv1), .w_ready(wr1), .w_out(wo1), .k_out(ko1), .w_idx(wi1), .w_last(wl1)
  );

  sha_msg_sched #(.ROUNDS(16)) u_dut16 (
    .clk(clk), .rst(rst), .blk_valid(bv2), .blk_ready(br2), .blk_data(blk_data),
    .w_valid(wv2), .w_ready(wr2), .w_out(wo2), .k_out(ko2), .w_idx(wi2), .w_last(wl2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] w_exp [64];
  logic [31:0] cap_w [64];
  logic [31:0] cap_k [64];
  logic [31:0] k_ref [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic build_exp(input logic [511:0] b);
    logic [31:0] s0, s1;
    for (int i = 0; i < 16; i++) w_exp[i] = b[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w_exp[i-15], 7) ^ rotr(w_exp[i-15], 18) ^ (w_exp[i-15] >> 3);
      s1 = rotr(w_exp[i-2], 17) ^ rotr(w_exp[i-2], 19) ^ (w_exp[i-2] >> 10);
      w_exp[i] = w_exp[i-16] + s0 + w_exp[i-7] + s1;
    end
  endtask

  function automatic logic [511:0] mk_block(input logic [31:0] seed);
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[511-32*i -: 32] = seed * 32'(i + 1) ^ 32'h5a5a_0000;
    return b;
  endfunction

  task automatic check_reset(input string p);
    check({p, "_blk_ready"}, 32'(m_br), 32'd1);
    check({p, "_w_valid"},   32'(m_wv), 32'd0);
    check({p, "_w_out"},     m_wo,      32'd0);
    check({p, "_k_out"},     m_ko,      32'h428a2f98);
    check({p, "_w_idx"},     32'(m_wi), 32'd0);
    check({p, "_w_last"},    32'(m_wl), 32'd0);
  endtask

  task automatic check_idle(input string p);
    check({p, "_idle_valid"}, 32'(m_wv), 32'd0);
    check({p, "_idle_ready"}, 32'(m_br), 32'd1);
  endtask

  // Called at a negedge with the block's W[0] expected on the outputs.
  task automatic consume(input int n, input int rounds, input int mode, input int drop_at,
                         output int cycles);
    int t = 0;
    int cyc = 0;
    logic hs;
    while (t < n && cyc < 4000) begin
      check($sformatf("w_valid[%0d]", t), 32'(m_wv), 32'd1);
      check($sformatf("blk_ready_run[%0d]", t), 32'(m_br), 32'd0);
      check($sformatf("w_out[%0d]", t), m_wo, w_exp[t]);
      check($sformatf("k_out[%0d]", t), m_ko, k_ref[t]);
      check($sformatf("w_idx[%0d]", t), 32'(m_wi), 32'(t));
      check($sformatf("w_last[%0d]", t), 32'(m_wl), 32'(t == rounds - 1));
      if (t == drop_at) blk_valid = 1'b0;
      w_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      hs = w_ready;
      if (hs) begin
        cap_w[t] = m_wo;
        cap_k[t] = m_ko;
      end
      @(negedge clk);
      cyc++;
      if (hs) t++;
    end
    if (t < n) check("consume_timeout", 32'(t), 32'(n));
    w_ready = 1'b1;
    cycles = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] abc;
    logic [511:0] b2;
    logic [511:0] b3;
    int cyc;
    time t0, t1;

    abc = '0;
    abc[511:480] = 32'h61626380;
    abc[31:0]    = 32'h00000018;
    b2 = mk_block(32'h9e3779b9);
    b3 = mk_block(32'h0badf00d);

    // Reset values on both builds
    repeat (2) @(negedge clk);
    check_reset("rst64");
    dut_sel = 1'b1;
    check_reset("rst16");
    dut_sel = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_idle("post_rst");

    // 1: "abc" block, consumer always ready
    build_exp(abc);
    blk_data = abc;
    blk_valid = 1'b1;
    @(negedge clk);
    blk_valid = 1'b0;
    consume(64, 64, 0, -1, cyc);
    check("t1_cycles", 32'(cyc), 32'd64);
    check("t1_W0",  cap_w[0],  32'h61626380);
    check("t1_W16", cap_w[16], 32'h61626380);
    check("t1_W17", cap_w[17], 32'h000F0000);
    check("t1_K0",  cap_k[0],  32'h428a2f98);
    check("t1_K63", cap_k[63], 32'hc67178f2);
    check_idle("t1");
    @(negedge clk);
    check_idle("t1b");
    check("t1_idle_idx", 32'(m_wi), 32'd0);
    check("t1_idle_last", 32'(m_wl), 32'd0);

    // 2: same block, random back-pressure
    blk_valid = 1'b1;
    @(negedge clk);
    blk_valid = 1'b0;
    consume(64, 64, 1, -1, cyc);
    check("t2_stalled", 32'(cyc > 64), 32'd1);
    check_idle("t2");

    // 3: blk_valid held high across blocks -> 65-cycle period
    blk_valid = 1'b1;
    @(negedge clk);
    t0 = $time;
    consume(64, 64, 0, -1, cyc);
    check_idle("t3_bubble");
    @(negedge clk);
    t1 = $time;
    check("t3_period", 32'((t1 - t0) / 10), 32'd65);
    consume(64, 64, 0, 5, cyc);
    check_idle("t3_end");

    // 4: a different block offered during RUN is ignored
    blk_data = abc;
    blk_valid = 1'b1;
    @(negedge clk);
    blk_data = b2;
    consume(64, 64, 0, 20, cyc);
    check_idle("t4");

    // 5: async reset at t=30, then a fresh block starts from W0
    build_exp(b2);
    blk_data = b2;
    blk_valid = 1'b1;
    @(negedge clk);
    blk_valid = 1'b0;
    consume(30, 64, 0, -1, cyc);
    check("t5_pre_idx", 32'(m_wi), 32'd30);
    rst = 1'b1;
    #1;
    check_reset("t5_async");
    @(negedge clk);
    rst = 1'b0;
    check_reset("t5_held");
    blk_valid = 1'b1;
    @(negedge clk);
    blk_valid = 1'b0;
    consume(64, 64, 1, -1, cyc);
    check_idle("t5_end");

    // 6: 16-round build emits the raw block words only
    dut_sel = 1'b1;
    build_exp(b3);
    blk_data = b3;
    blk_valid = 1'b1;
    @(negedge clk);
    blk_valid = 1'b0;
    consume(16, 16, 0, -1, cyc);
    check("t6_cycles", 32'(cyc), 32'd16);
    check_idle("t6");
    check("t6_idle_idx", 32'(m_wi), 32'd0);
    check("t6_idle_last", 32'(m_wl), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
